// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi: N-digit up/down BCD counter with enable, sanitising parallel load (load_err pulse), wrap/saturate, combinational tc; ports clk, reset_n, en, up_dn, load, load_val -> count, tc, load_err
module bcd_counter_multi #(
  parameter int NUM_DIGITS = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc,
  output logic                    load_err
);
  localparam int W = 4*NUM_DIGITS;
  logic [NUM_DIGITS-1:0] is9, is0, bad;
  logic [W-1:0] stepped, clean;
  logic term;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_d
    localparam logic [NUM_DIGITS-1:0] M = NUM_DIGITS'((64'd1 << i) - 64'd1);
    logic [3:0] d, lv, inc, dec;
    logic lo9, lo0;
    assign d = count[4*i+:4];
    assign lv = load_val[4*i+:4];
    assign is9[i] = d == 4'd9;
    assign is0[i] = d == 4'd0;
    assign lo9 = (is9 & M) == M;
    assign lo0 = (is0 & M) == M;
    assign inc = is9[i] ? 4'd0 : d + 4'd1;
    assign dec = is0[i] ? 4'd9 : d - 4'd1;
    assign stepped[4*i+:4] = up_dn ? (lo9 ? inc : d) : (lo0 ? dec : d);
    assign bad[i] = lv > 4'd9;
    assign clean[4*i+:4] = bad[i] ? 4'd0 : lv;
  end
  assign term = up_dn ? &is9 : &is0;
  assign tc = en & ~load & term;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= load & |bad;
      if (load) count <= clean;
      else if (en && !(SATURATE && term)) count <= stepped;
    end
  end
endmodule

// File: tb/tb_bcd_counter_multi.sv
// tb_bcd_counter_multi: randomized and directed checks of three counter instances against a decimal-integer model
module tb_bcd_counter_multi;
  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [7:0] c0, c1;
  logic [15:0] c4;
  logic t0, t1, t4, e0, e1, e4;
  int mv[3];
  bit lexp[3];
  int nd[3] = '{2, 2, 4};
  bit sat[3] = '{1'b0, 1'b1, 1'b0};
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  bcd_counter_multi #(.NUM_DIGITS(2), .SATURATE(1'b0)) u0 (.clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val[7:0]), .count(c0), .tc(t0), .load_err(e0));
  bcd_counter_multi #(.NUM_DIGITS(2), .SATURATE(1'b1)) u1 (.clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val[7:0]), .count(c1), .tc(t1), .load_err(e1));
  bcd_counter_multi #(.NUM_DIGITS(4), .SATURATE(1'b0)) u4 (.clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .count(c4), .tc(t4), .load_err(e4));
  function automatic int maxv(int n);
    int p = 1;
    for (int i = 0; i < n; i++) p *= 10;
    return p - 1;
  endfunction
  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v /= 10;
    end
    return r;
  endfunction
  function automatic logic [15:0] act_cnt(int k);
    return k == 0 ? {8'h00, c0} : k == 1 ? {8'h00, c1} : c4;
  endfunction
  function automatic logic act_tc(int k);
    return k == 0 ? t0 : k == 1 ? t1 : t4;
  endfunction
  function automatic logic act_le(int k);
    return k == 0 ? e0 : k == 1 ? e1 : e4;
  endfunction
  function automatic logic exp_tc(int k);
    return en && !load && (up_dn ? mv[k] == maxv(nd[k]) : mv[k] == 0);
  endfunction
  task automatic tick();
    int nv[3];
    bit nl[3];
    for (int k = 0; k < 3; k++) begin
      int mx = maxv(nd[k]);
      nl[k] = 1'b0;
      nv[k] = mv[k];
      if (load) begin
        int p = 1;
        nv[k] = 0;
        for (int i = 0; i < nd[k]; i++) begin
          int d = int'(load_val[4*i+:4]);
          if (d > 9) begin
            nl[k] = 1'b1;
            d = 0;
          end
          nv[k] += d * p;
          p *= 10;
        end
      end else if (en && up_dn) nv[k] = mv[k] == mx ? (sat[k] ? mx : 0) : mv[k] + 1;
      else if (en) nv[k] = mv[k] == 0 ? (sat[k] ? 0 : mx) : mv[k] - 1;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      mv[k] = reset_n ? nv[k] : 0;
      lexp[k] = reset_n ? nl[k] : 1'b0;
    end
  endtask
  task automatic test_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_cnt(k) !== 16'h0 || act_le(k) !== 1'b0) begin
        failures++;
        $display("FAIL reset k=%0d count=%h load_err=%b want 0000 0", k, act_cnt(k), act_le(k));
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask
  task automatic test_up_wrap();
    en = 1'b1;
    up_dn = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_tc(k) !== exp_tc(k)) begin
          failures++;
          $display("FAIL up_wrap_tc k=%0d n=%0d tc=%b want %b", k, n, act_tc(k), exp_tc(k));
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_cnt(k) !== to_bcd(mv[k])) begin
          failures++;
          $display("FAIL up_wrap k=%0d n=%0d count=%h want %h", k, n, act_cnt(k), to_bcd(mv[k]));
        end
      end
    end
    checks++;
    if (c0 !== 8'h00) begin
      failures++;
      $display("FAIL up_wrap_final count=%h want 00", c0);
    end
  endtask
  task automatic test_down();
    logic [7:0] s[7] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99, 8'h98};
    load = 1'b1;
    load_val = 16'h0005;
    tick();
    load = 1'b0;
    en = 1'b1;
    up_dn = 1'b0;
    for (int n = 0; n < 7; n++) begin
      #1;
      checks++;
      if (t0 !== (n == 5) || t0 !== exp_tc(0)) begin
        failures++;
        $display("FAIL down_tc n=%0d tc=%b want %b", n, t0, n == 5);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_cnt(k) !== to_bcd(mv[k]) || (k == 0 && c0 !== s[n])) begin
          failures++;
          $display("FAIL down k=%0d n=%0d count=%h want %h", k, n, act_cnt(k), to_bcd(mv[k]));
        end
      end
    end
  endtask
  task automatic test_saturate();
    logic [7:0] s[5] = '{8'h98, 8'h99, 8'h99, 8'h99, 8'h99};
    load = 1'b1;
    load_val = 16'h0097;
    tick();
    load = 1'b0;
    en = 1'b1;
    up_dn = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (n == 5) up_dn = 1'b0;
      #1;
      checks++;
      if (t1 !== (n >= 2 && n < 5) || t0 !== exp_tc(0)) begin
        failures++;
        $display("FAIL sat_tc n=%0d tc=%b/%b want %b/%b", n, t1, t0, n >= 2 && n < 5, exp_tc(0));
      end
      tick();
      checks++;
      if (c1 !== (n == 5 ? 8'h98 : s[n]) || c0 !== to_bcd(mv[0])) begin
        failures++;
        $display("FAIL sat n=%0d count=%h/%h want %h/%h", n, c1, c0, n == 5 ? 8'h98 : s[n], to_bcd(mv[0]));
      end
    end
  endtask
  task automatic test_load_err();
    logic [15:0] lv[2] = '{16'h003C, 16'h0042};
    logic [7:0] cv[2] = '{8'h30, 8'h42};
    en = 1'b1;
    load = 1'b1;
    for (int n = 0; n < 2; n++) begin
      load_val = lv[n];
      #1;
      checks++;
      if ({t0, t1, t4} !== 3'b000) begin
        failures++;
        $display("FAIL load_tc n=%0d tc=%b%b%b want 000", n, t0, t1, t4);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_cnt(k) !== {8'h00, cv[n]} || act_le(k) !== (n == 0) || act_le(k) !== lexp[k]) begin
          failures++;
          $display("FAIL load k=%0d n=%0d count=%h err=%b want %h %b", k, n, act_cnt(k), act_le(k), cv[n], n == 0);
        end
      end
    end
    load = 1'b0;
  endtask
  task automatic test_async_reset();
    load = 1'b1;
    load_val = 16'h0057;
    tick();
    load = 1'b0;
    en = 1'b1;
    up_dn = 1'b1;
    #2;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) mv[k] = 0;
    for (int n = 0; n < 3; n++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_cnt(k) !== 16'h0 || act_le(k) !== 1'b0) begin
          failures++;
          $display("FAIL async_reset k=%0d n=%0d count=%h want 0000", k, n, act_cnt(k));
        end
      end
      if (n < 2) tick();
    end
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_cnt(k) !== 16'h0001 || act_cnt(k) !== to_bcd(mv[k])) begin
        failures++;
        $display("FAIL reset_release k=%0d count=%h want 0001", k, act_cnt(k));
      end
    end
  endtask
  task automatic test_hold_toggle();
    load = 1'b1;
    load_val = 16'h0099;
    tick();
    load = 1'b0;
    en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      up_dn = n[0];
      #1;
      checks++;
      if ({t0, t1, t4} !== 3'b000) begin
        failures++;
        $display("FAIL hold_tc n=%0d tc=%b%b%b want 000", n, t0, t1, t4);
      end
      tick();
      checks++;
      if (c0 !== 8'h99 || c1 !== 8'h99 || c4 !== 16'h0099) begin
        failures++;
        $display("FAIL hold n=%0d count=%h %h %h want 99", n, c0, c1, c4);
      end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en = 1'($urandom_range(0, 3) != 0);
      up_dn = 1'($urandom);
      load = 1'($urandom_range(0, 7) == 0);
      load_val = 16'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_tc(k) !== exp_tc(k)) begin
          failures++;
          $display("FAIL rand_tc k=%0d n=%0d tc=%b want %b", k, n, act_tc(k), exp_tc(k));
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_cnt(k) !== to_bcd(mv[k]) || act_le(k) !== lexp[k]) begin
          failures++;
          $display("FAIL rand k=%0d n=%0d count=%h err=%b want %h %b", k, n, act_cnt(k), act_le(k), to_bcd(mv[k]), lexp[k]);
        end
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0;
      lexp[k] = 1'b0;
    end
    test_reset();
    test_up_wrap();
    test_down();
    test_saturate();
    test_load_err();
    test_async_reset();
    test_hold_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
Parametrised multi-digit synchronous BCD counter, the next generation of the team's single-digit BCD counter. Adds a configurable digit count, up/down direction, count enable, synchronous parallel load with digit validation, and a selectable wrap or saturate mode. The terminal-count output is combinational so instances can be cascaded. Used for decimal event counters and display timebases.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; range 1..8; count width is 4*NUM_DIGITS.
- SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; advance one step per enabled cycle.
- up_dn  input  1  direction; 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*NUM_DIGITS  BCD load value; digit i is at bits [4i+3:4i].
- count  output  4*NUM_DIGITS  registered BCD count; digit 0 is the least significant.
- tc  output  1  combinational terminal count; high when the next enabled step crosses the terminal value.
- load_err  output  1  registered; one-cycle pulse when a load contained an invalid digit.

Behaviour:
- Reset: asserting reset_n=0 immediately clears count to 0 and load_err to 0, regardless of clk. Deassertion is synchronous to the design; the first update happens on the first rising edge with reset_n=1.
- Priority at each rising edge: load > en > hold.
- Load: count <= load_val, with each digit >9 replaced by 0. load_err <= 1 for exactly one cycle if any digit was >9, otherwise 0. Load ignores en, up_dn and SATURATE.
- Hold (load=0, en=0): count is unchanged; load_err <= 0.
- Count up (en=1, up_dn=1):
  - Digit 0 increments; 9 -> 0.
  - Digit i (i>0) steps only when all lower digits are 9; 9 -> 0.
  - The all-9s terminal value goes to all-0s when SATURATE=0 and holds at all-9s when SATURATE=1.
- Count down (en=1, up_dn=0):
  - Digit 0 decrements; 0 -> 9.
  - Digit i (i>0) steps only when all lower digits are 0; 0 -> 9.
  - All-0s goes to all-9s when SATURATE=0 and holds at all-0s when SATURATE=1.
- tc = en & ~load & ((up_dn & count==all-9s) | (~up_dn & count==all-0s)).
  - tc is asserted in both modes.
  - In saturate mode tc stays high while the counter is pinned and enabled.
- Direction change: up_dn may change on any cycle and takes effect on that same edge. There is no pipeline and no state other than count and load_err.
- Latency: count reflects load or increment one edge after the inputs are sampled. tc has zero latency relative to inputs and count.
- Invalid held state: count digits are never >9 in operation. This is reachable only via load, which sanitises the value.
- Reset mid-count or mid-load: reset wins immediately; a load pending on the same edge is discarded.
- Cascading: the next stage's en is driven from the lower stage's tc, and both stages share up_dn.

Test Plan:
- NUM_DIGITS=2, SATURATE=0: reset, then hold en=1, up_dn=1 for 100 cycles -> count runs 00,01,...,09,10,...,99,00. tc is high only while count=99, and the count is 00 after cycle 100.
- NUM_DIGITS=2: load load_val=0x05, then en=1, up_dn=0 for 7 cycles -> count 04,03,02,01,00,99,98. tc is high only in the cycle where count=00.
- NUM_DIGITS=2, SATURATE=1: load 0x97, then count up 5 cycles -> 98,99,99,99,99 with tc held high from count=99. Switch up_dn=0 -> 98 on the next edge.
- Load 0x3C with en=1 on the same edge -> count=0x30 (load wins, digit C replaced by 0) and load_err pulses 1 for one cycle. A following valid load of 0x42 -> count=0x42, load_err=0.
- Drop reset_n to 0 asynchronously mid-cycle while count=0x57 and en=1 -> count=0x00 before the next clk edge and stays 0 while reset_n=0. After release it counts 01 on the first enabled edge.
- en=0 with up_dn toggling for 10 cycles at count=0x99 -> count unchanged and tc=0 throughout.
